// File: rtl/priority_interrupt_queue.sv
// Priority interrupt queue: captures edge/level requests into a pending set and
// admits the lowest-index pending source per cycle into an in-order vector FIFO.
module priority_interrupt_queue #(
    parameter  int SOURCES   = 8,
    parameter  int DEPTH     = 4,
    parameter  int EDGE_MODE = 1,
    localparam int VW        = $clog2(SOURCES),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SOURCES-1:0] irq_in,
    input  logic [SOURCES-1:0] irq_mask,
    input  logic               processing,
    input  logic               clear_dropped,
    output logic               vector_valid,
    output logic [VW-1:0]      vector_out,
    output logic [CW-1:0]      count,
    output logic               dropped
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SOURCES-1:0] irq_prev;
    logic [SOURCES-1:0] pending;
    logic [SOURCES-1:0] queued;
    logic [VW-1:0]      fifo [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic               last_proc;

    logic [SOURCES-1:0] evt;
    logic [SOURCES-1:0] acc;
    logic [SOURCES-1:0] cand;
    logic [SOURCES-1:0] pending_nxt;
    logic [SOURCES-1:0] queued_nxt;
    logic [VW-1:0]      sel;
    logic [VW-1:0]      head;
    logic               pop;
    logic               enq;
    logic               drop;
    logic [CW-1:0]      count_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head         = fifo[rd_ptr];
    assign vector_valid = (count != '0);
    assign vector_out   = (count != '0) ? head : '0;

    always_comb begin
        evt  = (EDGE_MODE != 0) ? (irq_in & ~irq_prev) : irq_in;
        acc  = evt & irq_mask;
        // A source whose mask dropped is not admitted; its pending bit is cleared below.
        cand = pending & irq_mask;
        sel  = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (cand[i]) sel = VW'(i);
        end
        pop  = last_proc && !processing && (count != '0);
        enq  = (|cand) && ((count < CW'(DEPTH)) || pop);
        drop = (EDGE_MODE != 0) && (|(acc & (pending | queued)));

        pending_nxt = (pending & irq_mask) | (acc & ~pending & ~queued);
        if (enq) pending_nxt[sel] = 1'b0;

        queued_nxt = queued;
        if (pop) queued_nxt[head] = 1'b0;
        if (enq) queued_nxt[sel]  = 1'b1;

        count_nxt = count;
        if (enq && !pop)      count_nxt = count + 1'b1;
        else if (pop && !enq) count_nxt = count - 1'b1;
    end

    always_ff @(negedge clk) begin
        // Capture the lines during reset so anything already high makes no edge at release.
        irq_prev <= irq_in;
        if (rst) begin
            pending   <= '0;
            queued    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            dropped   <= 1'b0;
            last_proc <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            last_proc <= processing;
            pending   <= pending_nxt;
            queued    <= queued_nxt;
            count     <= count_nxt;
            if (clear_dropped)  dropped <= 1'b0;
            else if (drop)      dropped <= 1'b1;
            // On a full FIFO with a pop, wr_ptr equals rd_ptr: the freed head slot takes the write.
            if (enq) begin
                fifo[wr_ptr] <= sel;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
        end
    end
endmodule
